// File: rtl/ip_header_rewrite.sv
`timescale 1ns/1ps
// ip_header_rewrite: egress header rewrite for forwarded IPv4 packets.
// Decrements TTL, regenerates the 20-byte IPv4 header checksum and passes
// everything else through bit-exact. Defining SRC_MAC_REWRITE_EN adds the
// mac* ports and replaces the source MAC of rewritten packets.
module ip_header_rewrite #(
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned DST_PORT_POS         = 24
) (
    input  logic                                AXI_ACLK,
    input  logic                                reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

`ifdef SRC_MAC_REWRITE_EN
    input  logic [31:0]                         mac0_low,
    input  logic [31:0]                         mac0_high,
    input  logic [31:0]                         mac1_low,
    input  logic [31:0]                         mac1_high,
    input  logic [31:0]                         mac2_low,
    input  logic [31:0]                         mac2_high,
    input  logic [31:0]                         mac3_low,
    input  logic [31:0]                         mac3_high,
`endif

    output logic [C_S_AXI_DATA_WIDTH-1:0]       rewrite_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       bypass_count
);

    localparam int unsigned DATA_W = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned STRB_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned USER_W = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned CNT_W  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned PORT_W = 8;
    localparam int unsigned ACC_W  = 20;

    // The source-port field is not consulted by this stage.
    localparam int unsigned unused_src_port_pos = SRC_PORT_POS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BODY,
        ST_DRAIN
    } state_t;

    state_t                 state;
    logic [DATA_W-1:0]      hold_data;
    logic [STRB_W-1:0]      hold_strb;
    logic [USER_W-1:0]      hold_user;
    logic                   hold_rewrite;

    logic                   out_free_c;
    logic                   rewrite_c;
    logic [PORT_W-1:0]      in_dst_c;
    logic [7:0]             ttl_dec_c;
    logic [ACC_W-1:0]       csum_acc_c;
    logic [16:0]            fold1_c;
    logic [15:0]            fold2_c;
    logic [DATA_W-1:0]      hdr_beat_c;

    // Output register can take a new beat when empty or being drained this cycle.
    assign out_free_c = !M_AXIS_TVALID || M_AXIS_TREADY;

    // Input backpressure: always open in IDLE, closed during DRAIN.
    assign S_AXIS_TREADY = (state == ST_IDLE) ||
                           (((state == ST_HOLD) || (state == ST_BODY)) && out_free_c);

    // Rewrite eligibility of an incoming beat 0 (forwarded IPv4, no options, TTL>1, non-CPU).
    always_comb begin
        in_dst_c  = S_AXIS_TUSER[DST_PORT_POS +: PORT_W];
        rewrite_c = (S_AXIS_TDATA[159:144] == 16'h0800) &&
                    (S_AXIS_TDATA[143:136] == 8'h45) &&
                    (S_AXIS_TDATA[79:72] > 8'd1) &&
                    !S_AXIS_TLAST &&
                    ((in_dst_c & 8'hAA) == 8'h00);
    end

`ifdef SRC_MAC_REWRITE_EN
    logic [PORT_W-1:0]      hold_dst_c;
    logic [47:0]            mac_sel_c;
    logic                   mac_hit_c;
    logic                   unused_mac_high;

    assign unused_mac_high = ^{mac0_high[31:16], mac1_high[31:16],
                               mac2_high[31:16], mac3_high[31:16]};

    // Lowest-numbered non-CPU destination port selects the new source MAC.
    always_comb begin
        hold_dst_c = hold_user[DST_PORT_POS +: PORT_W];
        mac_hit_c  = 1'b1;
        mac_sel_c  = '0;
        if (hold_dst_c[0])      mac_sel_c = {mac0_high[15:0], mac0_low};
        else if (hold_dst_c[2]) mac_sel_c = {mac1_high[15:0], mac1_low};
        else if (hold_dst_c[4]) mac_sel_c = {mac2_high[15:0], mac2_low};
        else if (hold_dst_c[6]) mac_sel_c = {mac3_high[15:0], mac3_low};
        else                    mac_hit_c = 1'b0;
    end
`endif

    // Rewritten beat 0: needs beat 1 on the input for the low half of the destination IP.
    always_comb begin
        ttl_dec_c  = hold_data[79:72] - 8'd1;
        csum_acc_c = ACC_W'(hold_data[143:128]) +
                     ACC_W'(hold_data[127:112]) +
                     ACC_W'(hold_data[111:96])  +
                     ACC_W'(hold_data[95:80])   +
                     ACC_W'({ttl_dec_c, hold_data[71:64]}) +
                     ACC_W'(hold_data[47:32])   +
                     ACC_W'(hold_data[31:16])   +
                     ACC_W'(hold_data[15:0])    +
                     ACC_W'(S_AXIS_TDATA[255:240]);
        fold1_c    = 17'(csum_acc_c[15:0]) + 17'(csum_acc_c[19:16]);
        fold2_c    = fold1_c[15:0] + 16'(fold1_c[16]);
        hdr_beat_c = hold_data;
        if (hold_rewrite) begin
            hdr_beat_c[79:72] = ttl_dec_c;
            hdr_beat_c[63:48] = ~fold2_c;
`ifdef SRC_MAC_REWRITE_EN
            if (mac_hit_c) begin
                hdr_beat_c[207:160] = mac_sel_c;
            end
`endif
        end
    end

    // Packet FSM with one-beat hold register, registered output stage and counters.
    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state         <= ST_IDLE;
            hold_data     <= '0;
            hold_strb     <= '0;
            hold_user     <= '0;
            hold_rewrite  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            rewrite_count <= '0;
            bypass_count  <= '0;
        end else begin
            if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (S_AXIS_TVALID) begin
                        hold_data    <= S_AXIS_TDATA;
                        hold_strb    <= S_AXIS_TSTRB;
                        hold_user    <= S_AXIS_TUSER;
                        hold_rewrite <= rewrite_c;
                        state        <= S_AXIS_TLAST ? ST_DRAIN : ST_HOLD;
                    end
                end
                ST_HOLD, ST_BODY: begin
                    if (S_AXIS_TVALID && out_free_c) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= (state == ST_HOLD) ? hdr_beat_c : hold_data;
                        M_AXIS_TSTRB  <= hold_strb;
                        M_AXIS_TUSER  <= hold_user;
                        M_AXIS_TLAST  <= 1'b0;
                        hold_data     <= S_AXIS_TDATA;
                        hold_strb     <= S_AXIS_TSTRB;
                        hold_user     <= S_AXIS_TUSER;
                        state         <= S_AXIS_TLAST ? ST_DRAIN : ST_BODY;
                    end
                end
                ST_DRAIN: begin
                    if (out_free_c) begin
                        M_AXIS_TVALID <= 1'b1;
                        M_AXIS_TDATA  <= hold_data;
                        M_AXIS_TSTRB  <= hold_strb;
                        M_AXIS_TUSER  <= hold_user;
                        M_AXIS_TLAST  <= 1'b1;
                        if (hold_rewrite) begin
                            rewrite_count <= rewrite_count + CNT_W'(1);
                        end else begin
                            bypass_count  <= bypass_count + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_rewrite.sv
`timescale 1ns/1ps
// tb_ip_header_rewrite: randomized and directed stimulus against a packet-level
// reference model (IPv4 checksum computed as a plain ones-complement sum).
module tb_ip_header_rewrite;

    localparam int DST_POS = 24;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
        logic         rw_first;
        logic [15:0]  b1w;
    } beat_t;

    logic         AXI_ACLK;
    logic         reset;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TSTRB;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TREADY;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic [31:0]  rewrite_count;
    logic [31:0]  bypass_count;
`ifdef SRC_MAC_REWRITE_EN
    logic [31:0]  mac_lo [4];
    logic [31:0]  mac_hi [4];
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    int           rdy_mode = 0;
    int           gap_en   = 0;
    int unsigned  exp_rw   = 0;
    int unsigned  exp_by   = 0;
    beat_t        pkt_q[$];
    beat_t        exp_q[$];
    logic [255:0] first_out;

    ip_header_rewrite dut (
        .AXI_ACLK      (AXI_ACLK),
        .reset         (reset),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TSTRB  (S_AXIS_TSTRB),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
`ifdef SRC_MAC_REWRITE_EN
        .mac0_low      (mac_lo[0]),
        .mac0_high     (mac_hi[0]),
        .mac1_low      (mac_lo[1]),
        .mac1_high     (mac_hi[1]),
        .mac2_low      (mac_lo[2]),
        .mac2_high     (mac_hi[2]),
        .mac3_low      (mac_lo[3]),
        .mac3_high     (mac_hi[3]),
`endif
        .rewrite_count (rewrite_count),
        .bypass_count  (bypass_count)
    );

    initial AXI_ACLK = 1'b0;
    always #5 AXI_ACLK = ~AXI_ACLK;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Ones-complement sum of the 10 header words (optionally leaving out the checksum word).
    function automatic logic [15:0] ones_sum(input logic [255:0] b0, input logic [15:0] b1w,
                                             input bit skip_csum);
        logic [159:0] hdr;
        int unsigned  s;
        hdr = {b0[143:0], b1w};
        s = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(skip_csum && i == 5)) s += 32'(hdr[159-16*i -: 16]);
        end
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return 16'(s);
    endfunction

    task automatic make_pkt(input int len, input logic [7:0] dst, input logic [15:0] etype,
                            input logic [7:0] ttl);
        beat_t b;
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.strb = (i == len - 1) ? $urandom : 32'hFFFF_FFFF;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.user[DST_POS +: 8] = dst;
            b.last = (i == len - 1);
            b.rw_first = 1'b0;
            b.b1w = 16'h0;
            if (i == 0) begin
                b.data[159:144] = etype;
                b.data[143:136] = 8'h45;
                b.data[79:72]   = ttl;
            end
            pkt_q.push_back(b);
        end
    endtask

    // Reference model: derive the expected output packet from the forwarding rules.
    task automatic model_pkt();
        beat_t      b;
        logic [7:0] dst;
        bit         rw;
        dst = pkt_q[0].user[DST_POS +: 8];
        rw  = (pkt_q[0].data[159:144] == 16'h0800) && (pkt_q[0].data[143:136] == 8'h45) &&
              (pkt_q[0].data[79:72] > 8'd1) && (pkt_q.size() > 1) && ((dst & 8'hAA) == 8'h00);
        for (int i = 0; i < pkt_q.size(); i++) begin
            b = pkt_q[i];
            if (i == 0 && rw) begin
                b.data[79:72] = b.data[79:72] - 8'd1;
                b.data[63:48] = ~ones_sum(b.data, pkt_q[1].data[255:240], 1'b1);
`ifdef SRC_MAC_REWRITE_EN
                for (int k = 0; k < 4; k++) begin
                    if (dst[2*k]) begin
                        b.data[207:160] = {mac_hi[k][15:0], mac_lo[k]};
                        break;
                    end
                end
`endif
                b.rw_first = 1'b1;
                b.b1w = pkt_q[1].data[255:240];
            end
            exp_q.push_back(b);
        end
        if (rw) exp_rw++;
        else    exp_by++;
    endtask

    task automatic send_beat(input beat_t b);
        int n;
        if (gap_en != 0) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge AXI_ACLK);
                #1;
            end
        end
        S_AXIS_TDATA  = b.data;
        S_AXIS_TSTRB  = b.strb;
        S_AXIS_TUSER  = b.user;
        S_AXIS_TLAST  = b.last;
        S_AXIS_TVALID = 1'b1;
        n = 0;
        forever begin
            @(negedge AXI_ACLK);
            if (S_AXIS_TREADY) begin
                @(posedge AXI_ACLK);
                #1;
                break;
            end
            @(posedge AXI_ACLK);
            #1;
            n++;
            if (n > 2000) begin
                chk("input_accept_timeout", 256'(n), 256'(0));
                break;
            end
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt_q.size(); i++) send_beat(pkt_q[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || M_AXIS_TVALID) && n < 1000) begin
            @(posedge AXI_ACLK);
            #1;
            n++;
        end
        chk("drain_timeout", 256'(exp_q.size()), 256'(0));
        repeat (2) begin
            @(posedge AXI_ACLK);
            #1;
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_rewrite_count"}, 256'(rewrite_count), 256'(exp_rw));
        chk({tag, "_bypass_count"},  256'(bypass_count),  256'(exp_by));
    endtask

    // Test-plan header 4500 0073 0000 4000 <ttl>11 b861 c0a80001 c0a8|00c7, 3 beats, dst port 0.
    task automatic make_tp(input logic [7:0] ttl);
        beat_t b;
        make_pkt(3, 8'h01, 16'h0800, ttl);
        b = pkt_q[0];
        b.data[143:0] = {16'h4500, 16'h0073, 16'h0000, 16'h4000, ttl, 8'h11, 16'hB861,
                         32'hC0A8_0001, 16'hC0A8};
        pkt_q[0] = b;
        b = pkt_q[1];
        b.data[255:240] = 16'h00C7;
        pkt_q[1] = b;
    endtask

    // Output-side ready pattern generator.
    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge AXI_ACLK);
            #1;
            case (rdy_mode)
                1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                2:       M_AXIS_TREADY = !M_AXIS_TREADY;
                default: M_AXIS_TREADY = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard compare, stall stability and header checksum validity.
    initial begin
        beat_t        e;
        logic         stalled;
        logic         out_sop;
        logic [255:0] st_data;
        logic         st_last;
        stalled = 1'b0;
        out_sop = 1'b1;
        st_data = '0;
        st_last = 1'b0;
        forever begin
            @(negedge AXI_ACLK);
            if (reset) begin
                stalled = 1'b0;
                out_sop = 1'b1;
                continue;
            end
            if (stalled) begin
                chk("stall_tvalid", 256'(M_AXIS_TVALID), 256'(1));
                chk("stall_tdata", M_AXIS_TDATA, st_data);
                chk("stall_tlast", 256'(M_AXIS_TLAST), 256'(st_last));
            end
            stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
            st_data = M_AXIS_TDATA;
            st_last = M_AXIS_TLAST;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", M_AXIS_TDATA, 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", M_AXIS_TDATA, e.data);
                    chk("tstrb", 256'(M_AXIS_TSTRB), 256'(e.strb));
                    chk("tuser", 256'(M_AXIS_TUSER), 256'(e.user));
                    chk("tlast", 256'(M_AXIS_TLAST), 256'(e.last));
                    if (e.rw_first)
                        chk("hdr_sum", 256'(ones_sum(M_AXIS_TDATA, e.b1w, 1'b0)), 256'(16'hFFFF));
                end
                if (out_sop) first_out = M_AXIS_TDATA;
                out_sop = M_AXIS_TLAST;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int          len;
        logic [7:0]  dst;
        logic [7:0]  ttl;
        logic [15:0] et;
        beat_t       b;

        reset         = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TSTRB  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        first_out     = '0;
`ifdef SRC_MAC_REWRITE_EN
        for (int k = 0; k < 4; k++) begin
            mac_lo[k] = $urandom;
            mac_hi[k] = $urandom;
        end
        mac_lo[1] = 32'h0C0D_0E0F;
        mac_hi[1] = 32'h0000_0A0B;
`endif
        repeat (3) @(posedge AXI_ACLK);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_m_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        chk("rst_m_tdata", M_AXIS_TDATA, 256'(0));
        chk("rst_m_tlast", 256'(M_AXIS_TLAST), 256'(0));
        chk("rst_s_tready", 256'(S_AXIS_TREADY), 256'(1));
        chk_counts("rst");

        // Test-plan packet: TTL 0x40 -> 0x3F, checksum 0xB961; beat 0 waits for beat 1
        make_tp(8'h40);
        model_pkt();
        send_beat(pkt_q[0]);
        repeat (3) begin
            @(posedge AXI_ACLK);
            #1;
        end
        chk("no_emit_before_beat1", 256'(M_AXIS_TVALID), 256'(0));
        send_beat(pkt_q[1]);
        chk("beat0_latency", 256'(M_AXIS_TVALID), 256'(1));
        send_beat(pkt_q[2]);
        wait_idle();
        chk("tp1_ttl", 256'(first_out[79:72]), 256'(8'h3F));
        chk("tp1_csum", 256'(first_out[63:48]), 256'(16'hB961));
        chk_counts("tp1");

        // TTL 1 -> untouched
        make_tp(8'h01);
        model_pkt();
        send_pkt();
        wait_idle();
        chk("ttl1_byte", 256'(first_out[79:72]), 256'(8'h01));
        chk_counts("ttl1");

        // ARP 2-beat and single-beat IPv4 -> bypass
        make_pkt(2, 8'h01, 16'h0806, 8'h40);
        model_pkt();
        send_pkt();
        make_pkt(1, 8'h01, 16'h0800, 8'h40);
        model_pkt();
        send_pkt();
        wait_idle();
        chk_counts("bypass");

        // Three back-to-back 4-beat IPv4 packets under a 1010 ready pattern
        rdy_mode = 2;
        for (int p = 0; p < 3; p++) begin
            make_pkt(4, 8'h01 << (2 * p), 16'h0800, 8'($urandom_range(2, 255)));
            model_pkt();
            send_pkt();
        end
        wait_idle();
        chk_counts("b2b");
        rdy_mode = 0;

`ifdef SRC_MAC_REWRITE_EN
        // Destination port 1 selects mac1 as new source MAC
        make_pkt(2, 8'h04, 16'h0800, 8'h20);
        model_pkt();
        send_pkt();
        wait_idle();
        chk("mac1_src", 256'(first_out[207:160]), 256'(48'h0A0B_0C0D_0E0F));
        chk_counts("mac");
`endif

        // Randomized traffic with input gaps and random output backpressure
        rdy_mode = 1;
        gap_en   = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            dst = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'h55);
            et  = ($urandom_range(0, 4) == 0) ? 16'h86DD : 16'h0800;
            case ($urandom_range(0, 4))
                0:       ttl = 8'h00;
                1:       ttl = 8'h01;
                2:       ttl = 8'h02;
                3:       ttl = 8'hFF;
                default: ttl = 8'($urandom);
            endcase
            make_pkt(len, dst, et, ttl);
            if ($urandom_range(0, 7) == 0) begin
                b = pkt_q[0];
                b.data[143:136] = 8'h46;
                pkt_q[0] = b;
            end
            model_pkt();
            send_pkt();
        end
        wait_idle();
        chk_counts("random");
        rdy_mode = 0;
        gap_en   = 0;

        // Reset in the body of a 5-beat packet, then one clean packet
        make_pkt(5, 8'h10, 16'h0800, 8'h33);
        model_pkt();
        for (int i = 0; i < 3; i++) send_beat(pkt_q[i]);
        repeat (4) begin
            @(posedge AXI_ACLK);
            #1;
        end
        chk("pre_reset_drained", 256'(exp_q.size()), 256'(3));
        exp_q.delete();
        exp_rw = 0;
        exp_by = 0;
        reset = 1'b1;
        @(posedge AXI_ACLK);
        #1;
        reset = 1'b0;
        chk("post_reset_tvalid", 256'(M_AXIS_TVALID), 256'(0));
        chk_counts("post_reset");
        make_pkt(3, 8'h40, 16'h0800, 8'h80);
        model_pkt();
        send_pkt();
        wait_idle();
        chk_counts("clean");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
